// File: rtl/vset_issue_pkg.sv
// Shared encodings for the vset issue slice: vset opcode fields, cfg_type and AVL-source codes, FSM states.
// Latency: n/a (constants only).
// Backpressure: n/a.
package vset_issue_pkg;

  localparam logic [6:0] OPC_VSET   = 7'b1010111;
  localparam logic [2:0] F3_VSET    = 3'b111;
  localparam logic [6:0] F7_VSETVL  = 7'b1000000;

  // cfg_type: which vset form was issued
  localparam logic [1:0] CFG_VSETVLI  = 2'b00;
  localparam logic [1:0] CFG_VSETIVLI = 2'b01;
  localparam logic [1:0] CFG_VSETVL   = 2'b11;

  // cfg_avl_set: where the configuration unit takes the AVL from
  localparam logic [1:0] AVL_REG   = 2'b00;
  localparam logic [1:0] AVL_IMM   = 2'b10;
  localparam logic [1:0] AVL_VLMAX = 2'b01;
  localparam logic [1:0] AVL_KEEP  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CFG    = 2'd1,
    ST_SETTLE = 2'd2,
    ST_WB     = 2'd3
  } state_e;

endpackage

// File: rtl/vset_issue_decode.sv
// Combinational decode of a vset instruction into configuration-unit fields plus a legal flag.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller qualifies the outputs with its own handshake.
module vset_issue_decode
  import vset_issue_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     insn_i,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] rs2_data_i,
  output logic            legal_o,
  output logic [XLEN-1:0] vtype_o,
  output logic [1:0]      cfg_type_o,
  output logic [1:0]      avl_set_o,
  output logic [31:0]     avl_new_o
);

  logic is_vset;

  // Classify the form from the top bits, then pick vtype/AVL and the AVL source.
  always_comb begin
    is_vset    = (insn_i[6:0] == OPC_VSET) && (insn_i[14:12] == F3_VSET);
    legal_o    = 1'b0;
    vtype_o    = '0;
    cfg_type_o = CFG_VSETVLI;
    avl_new_o  = rs1_data_i[31:0];
    avl_set_o  = AVL_REG;
    if (!insn_i[31]) begin
      legal_o    = is_vset;
      cfg_type_o = CFG_VSETVLI;
      vtype_o    = {{(XLEN-11){1'b0}}, insn_i[30:20]};
    end else if (insn_i[30]) begin
      legal_o    = is_vset;
      cfg_type_o = CFG_VSETIVLI;
      vtype_o    = {{(XLEN-10){1'b0}}, insn_i[29:20]};
      avl_new_o  = {27'd0, insn_i[19:15]};
    end else if (insn_i[31:25] == F7_VSETVL) begin
      legal_o    = is_vset;
      cfg_type_o = CFG_VSETVL;
      vtype_o    = rs2_data_i;
    end
    // Immediate AVL wins; otherwise rs1=x0 means VLMAX (rd!=x0) or keep current vl (rd=x0).
    if (cfg_type_o == CFG_VSETIVLI)   avl_set_o = AVL_IMM;
    else if (insn_i[19:15] != 5'd0)   avl_set_o = AVL_REG;
    else if (insn_i[11:7] != 5'd0)    avl_set_o = AVL_VLMAX;
    else                              avl_set_o = AVL_KEEP;
  end

endmodule

// File: rtl/vset_issue.sv
// Issues vset instructions to the vector configuration unit and writes the granted vl back to rd.
// Latency: accept c0, cfg_en c1, wb_valid c3, next accept c4 with wb_ready high.
// Backpressure: insn_ready only in IDLE; WB holds wb_* stable until wb_ready.
module vset_issue
  import vset_issue_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int VLEN        = 16384,
  parameter int VLMAX       = VLEN >> 3,
  parameter int VLEN_B_BITS = $clog2(VLMAX)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 insn_valid,
  output logic                 insn_ready,
  input  logic [31:0]          insn,
  input  logic [XLEN-1:0]      rs1_data,
  input  logic [XLEN-1:0]      rs2_data,
  output logic                 cfg_en,
  output logic [XLEN-1:0]      cfg_vtype,
  output logic [1:0]           cfg_type,
  output logic [1:0]           cfg_avl_set,
  output logic [31:0]          cfg_avl_new,
  input  logic [VLEN_B_BITS:0] cfg_avl,
  input  logic                 cfg_vill,
  input  logic                 cfg_new_vl,
  output logic                 wb_valid,
  input  logic                 wb_ready,
  output logic [4:0]           wb_rd,
  output logic [XLEN-1:0]      wb_data,
  output logic                 illegal
);

  state_e          state_q, state_d;
  logic            live_q;
  logic            illegal_q;
  logic [XLEN-1:0] vtype_q;
  logic [1:0]      type_q, avl_set_q;
  logic [31:0]     avl_new_q;
  logic [4:0]      rd_q;
  logic [XLEN-1:0] wb_data_q;

  logic            dec_legal;
  logic [XLEN-1:0] dec_vtype;
  logic [1:0]      dec_type, dec_avl_set;
  logic [31:0]     dec_avl_new;
  logic            insn_hs;

  vset_issue_decode #(.XLEN(XLEN)) u_decode (
    .insn_i     (insn),
    .rs1_data_i (rs1_data),
    .rs2_data_i (rs2_data),
    .legal_o    (dec_legal),
    .vtype_o    (dec_vtype),
    .cfg_type_o (dec_type),
    .avl_set_o  (dec_avl_set),
    .avl_new_o  (dec_avl_new)
  );

  // live_q keeps insn_ready low while in reset and for the release cycle.
  assign insn_ready  = live_q && (state_q == ST_IDLE);
  assign insn_hs     = insn_valid && insn_ready;
  assign illegal     = illegal_q;
  assign cfg_vtype   = vtype_q;
  assign cfg_type    = type_q;
  assign cfg_avl_set = avl_set_q;
  assign cfg_avl_new = avl_new_q;
  assign wb_rd       = rd_q;
  assign wb_data     = wb_data_q;

  // Next-state and state-decoded strobes.
  always_comb begin
    state_d  = state_q;
    cfg_en   = 1'b0;
    wb_valid = 1'b0;
    case (state_q)
      ST_IDLE:   if (insn_hs && dec_legal) state_d = ST_CFG;
      ST_CFG: begin
        cfg_en  = 1'b1;
        state_d = ST_SETTLE;
      end
      ST_SETTLE: state_d = (cfg_new_vl && (rd_q != 5'd0)) ? ST_WB : ST_IDLE;
      ST_WB: begin
        wb_valid = 1'b1;
        if (wb_ready) state_d = ST_IDLE;
      end
      default:   state_d = ST_IDLE;
    endcase
  end

  // State register; reset aborts any pending writeback.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      live_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      live_q    <= 1'b1;
      illegal_q <= insn_hs && !dec_legal;
    end
  end

  // Capture decoded fields on an accepted vset; they hold until the next one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vtype_q   <= '0;
      type_q    <= '0;
      avl_set_q <= '0;
      avl_new_q <= '0;
      rd_q      <= '0;
    end else if (insn_hs && dec_legal) begin
      vtype_q   <= dec_vtype;
      type_q    <= dec_type;
      avl_set_q <= dec_avl_set;
      avl_new_q <= dec_avl_new;
      rd_q      <= insn[11:7];
    end
  end

  // Sample the configuration unit's answer in SETTLE; an illegal vtype writes vl=0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_data_q <= '0;
    end else if (state_q == ST_SETTLE) begin
      wb_data_q <= cfg_vill ? '0 : {{(XLEN-VLEN_B_BITS-1){1'b0}}, cfg_avl};
    end
  end

endmodule

// File: tb/tb_vset_issue.sv
// Scoreboard bench for vset_issue: directed vset/illegal vectors, latency and reset-abort checks.
// Latency: n/a.
// Backpressure: exercises wb_ready held low and reset during writeback.
module tb_vset_issue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        insn_valid;
  logic        insn_ready;
  logic [31:0] insn;
  logic [31:0] rs1_data, rs2_data;
  logic        cfg_en;
  logic [31:0] cfg_vtype;
  logic [1:0]  cfg_type, cfg_avl_set;
  logic [31:0] cfg_avl_new;
  logic [11:0] cfg_avl;
  logic        cfg_vill, cfg_new_vl;
  logic        wb_valid, wb_ready;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        illegal;

  vset_issue dut (
    .clk(clk), .rst_n(rst_n),
    .insn_valid(insn_valid), .insn_ready(insn_ready), .insn(insn),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .cfg_en(cfg_en), .cfg_vtype(cfg_vtype), .cfg_type(cfg_type),
    .cfg_avl_set(cfg_avl_set), .cfg_avl_new(cfg_avl_new),
    .cfg_avl(cfg_avl), .cfg_vill(cfg_vill), .cfg_new_vl(cfg_new_vl),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
    .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] vtype;
    logic [1:0]  ctype;
    logic [1:0]  aset;
    logic [31:0] anew;
  } exp_cfg_t;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } exp_wb_t;

  exp_cfg_t cfg_q[$];
  exp_wb_t  wb_q[$];
  int       ill_q[$];
  exp_cfg_t ec;
  exp_wb_t  ew;
  int       n_pass = 0;
  int       n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Monitor: pop the expected response whenever the DUT presents one.
  always @(negedge clk) begin
    if (rst_n) begin
      if (cfg_en) begin
        chk("cfg_en_expected", cfg_q.size() != 0, 1'b1);
        if (cfg_q.size() != 0) begin
          ec = cfg_q.pop_front();
          chk("cfg_vtype", cfg_vtype, ec.vtype);
          chk("cfg_type", cfg_type, ec.ctype);
          chk("cfg_avl_set", cfg_avl_set, ec.aset);
          chk("cfg_avl_new", cfg_avl_new, ec.anew);
        end
      end
      if (wb_valid && wb_ready) begin
        chk("wb_expected", wb_q.size() != 0, 1'b1);
        if (wb_q.size() != 0) begin
          ew = wb_q.pop_front();
          chk("wb_rd", wb_rd, ew.rd);
          chk("wb_data", wb_data, ew.data);
        end
      end
      if (illegal) begin
        chk("illegal_expected", ill_q.size() != 0, 1'b1);
        if (ill_q.size() != 0) void'(ill_q.pop_front());
      end
    end
  end

  task automatic issue(input logic [31:0] i, input logic [31:0] r1, input logic [31:0] r2);
    logic ok;
    @(posedge clk); #1;
    insn_valid = 1'b1; insn = i; rs1_data = r1; rs2_data = r2;
    ok = 1'b0;
    for (int n = 0; n < 20 && !ok; n++) begin
      @(negedge clk);
      ok = insn_ready;
    end
    chk("accept_timeout", ok, 1'b1);
    @(posedge clk); #1;
    insn_valid = 1'b0;
  endtask

  // One legal vset: cycle 1 cfg_en, cycle 3 wb_valid or insn_ready.
  task automatic run(input logic [31:0] i, input logic [31:0] r1, input logic [31:0] r2,
                     input logic [11:0] avl, input logic vill, input logic nvl, input int hold,
                     input logic [31:0] e_vtype, input logic [1:0] e_type, input logic [1:0] e_set,
                     input logic [31:0] e_anew, input logic e_wb, input logic [4:0] e_rd,
                     input logic [31:0] e_data);
    exp_cfg_t c;
    exp_wb_t  w;
    c.vtype = e_vtype; c.ctype = e_type; c.aset = e_set; c.anew = e_anew;
    cfg_q.push_back(c);
    if (e_wb) begin
      w.rd = e_rd; w.data = e_data;
      wb_q.push_back(w);
    end
    cfg_avl = avl; cfg_vill = vill; cfg_new_vl = nvl;
    wb_ready = (hold == 0);
    issue(i, r1, r2);
    @(negedge clk); chk("lat_cfg_en_c1", cfg_en, 1'b1);
    @(negedge clk); chk("cfg_en_one_cycle", cfg_en, 1'b0);
    chk("cfg_vtype_hold", cfg_vtype, e_vtype);
    @(negedge clk);
    if (e_wb) begin
      chk("lat_wb_valid_c3", wb_valid, 1'b1);
      if (hold > 0) begin
        for (int k = 0; k < hold; k++) begin
          if (k > 0) @(negedge clk);
          chk("wb_hold_valid", wb_valid, 1'b1);
          chk("wb_hold_data", wb_data, e_data);
          chk("wb_hold_ready_low", insn_ready, 1'b0);
        end
        @(posedge clk); #1; wb_ready = 1'b1;
        @(negedge clk); chk("wb_valid_at_hs", wb_valid, 1'b1);
      end
      @(negedge clk); chk("ready_after_wb", insn_ready, 1'b1);
      chk("wb_valid_dropped", wb_valid, 1'b0);
    end else begin
      chk("no_wb_valid", wb_valid, 1'b0);
      chk("ready_at_c3", insn_ready, 1'b1);
    end
  endtask

  task automatic run_illegal(input logic [31:0] i);
    ill_q.push_back(1);
    issue(i, 32'h1, 32'h2);
    @(negedge clk);
    chk("illegal_pulse", illegal, 1'b1);
    chk("illegal_no_cfg_en", cfg_en, 1'b0);
    @(negedge clk);
    chk("illegal_once", illegal, 1'b0);
    chk("illegal_no_cfg_en2", cfg_en, 1'b0);
    chk("illegal_stay_idle", insn_ready, 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; insn_valid = 1'b0; insn = '0; rs1_data = '0; rs2_data = '0;
    cfg_avl = '0; cfg_vill = 1'b0; cfg_new_vl = 1'b0; wb_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs",
        {insn_ready, cfg_en, cfg_vtype, cfg_type, cfg_avl_set, cfg_avl_new,
         wb_valid, wb_rd, wb_data, illegal}, '0);
    @(posedge clk); #1; rst_n = 1'b1;
    @(negedge clk); chk("ready_low_release_cycle", insn_ready, 1'b0);
    @(negedge clk); chk("ready_after_release", insn_ready, 1'b1);

    // vsetvli x5, x6, vtype 0x0C0 (e8): rs1_data=100 -> avl 100
    run(32'h0C0372D7, 32'd100, 32'h0, 12'd100, 1'b0, 1'b1, 0,
        32'h0C0, 2'b00, 2'b00, 32'd100, 1'b1, 5'd5, 32'd100);
    // vsetivli x1, uimm=17, vtype 0x010
    run(32'hC108F0D7, 32'hDEADBEEF, 32'h0, 12'd17, 1'b0, 1'b1, 0,
        32'h010, 2'b01, 2'b10, 32'd17, 1'b1, 5'd1, 32'd17);
    // vsetvli x0, x0, vtype 0x0D1: keep vl, no writeback
    run(32'h0D107057, 32'h1234, 32'h0, 12'd0, 1'b0, 1'b0, 0,
        32'h0D1, 2'b00, 2'b11, 32'h1234, 1'b0, 5'd0, 32'd0);
    // vsetvl x3, x4, x7 with vill=1, wb_ready low for 5 cycles -> vl=0
    run(32'h807271D7, 32'd50, 32'h80000000, 12'd50, 1'b1, 1'b1, 5,
        32'h80000000, 2'b11, 2'b00, 32'd50, 1'b1, 5'd3, 32'd0);
    // vsetvli x2, x0, vtype 0x008: VLMAX request, max granted vl 2048
    run(32'h00807157, 32'd7, 32'h0, 12'd2048, 1'b0, 1'b1, 0,
        32'h008, 2'b00, 2'b01, 32'd7, 1'b1, 5'd2, 32'd2048);

    run_illegal(32'h00000013);   // addi
    run_illegal(32'hA0007057);   // vset opcode/funct3, insn[31:30]=10 but not vsetvl
    run_illegal(32'h00000057);   // vector opcode, funct3=000

    // Reset during WB: pending writeback is dropped at once
    cfg_q.push_back('{32'h0C0, 2'b00, 2'b00, 32'd100});
    cfg_avl = 12'd100; cfg_vill = 1'b0; cfg_new_vl = 1'b1; wb_ready = 1'b0;
    issue(32'h0C0372D7, 32'd100, 32'h0);
    repeat (3) @(negedge clk);
    chk("abort_wb_valid_before", wb_valid, 1'b1);
    @(posedge clk); #2; rst_n = 1'b0;
    #1;
    chk("abort_wb_valid_now", wb_valid, 1'b0);
    chk("abort_ready_low", insn_ready, 1'b0);
    @(posedge clk); #1; rst_n = 1'b1; wb_ready = 1'b1;
    run(32'hC108F0D7, 32'h0, 32'h0, 12'd16, 1'b0, 1'b1, 0,
        32'h010, 2'b01, 2'b10, 32'd17, 1'b1, 5'd1, 32'd16);

    repeat (3) @(negedge clk);
    chk("cfg_q_drained", cfg_q.size(), 0);
    chk("wb_q_drained", wb_q.size(), 0);
    chk("ill_q_drained", ill_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/vset_issue.md
VSET_ISSUE -- requirements
Module: vset_issue

Interface
REQ-001 Parameter XLEN, default 32, scalar register width.
REQ-002 Parameter VLEN, default 16384, vector register length in bits.
REQ-003 Parameter VLMAX, default VLEN>>3, maximum vector length in elements.
REQ-004 Parameter VLEN_B_BITS, default $clog2(VLMAX), width of the element-count index.
REQ-005 clk  in  1  sole clock; all state updates on rising edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 insn_valid  in  1  instruction offered.
REQ-008 insn_ready  out  1  instruction accepted this cycle when both valid and ready are high.
REQ-009 insn  in  32  instruction word.
REQ-010 rs1_data  in  XLEN  scalar rs1 value, sampled with insn.
REQ-011 rs2_data  in  XLEN  scalar rs2 value, sampled with insn.
REQ-012 cfg_en  out  1  one-cycle update strobe to the configuration unit.
REQ-013 cfg_vtype  out  XLEN  new vtype.
REQ-014 cfg_type  out  2  instruction form: 00 vsetvli, 01 vsetivli, 11 vsetvl.
REQ-015 cfg_avl_set  out  2  AVL source: 00 register, 10 immediate, 01 VLMAX, 11 keep.
REQ-016 cfg_avl_new  out  32  requested AVL.
REQ-017 cfg_avl  in  VLEN_B_BITS+1  granted vl.
REQ-018 cfg_vill  in  1  illegal vtype flag.
REQ-019 cfg_new_vl  in  1  the configuration unit produced a new vl.
REQ-020 wb_valid  out  1  vl writeback offered.
REQ-021 wb_ready  in  1  scalar writeback port accepts.
REQ-022 wb_rd  out  5  destination register.
REQ-023 wb_data  out  XLEN  written vl value.
REQ-024 illegal  out  1  one-cycle pulse when an accepted insn is not a vset form.

Function
REQ-025 A vset insn SHALL be opcode 7'b1010111 with funct3 3'b111; insn[31]=0 is vsetvli, insn[31:30]=11 is vsetivli, insn[31:25]=7'b1000000 is vsetvl; anything else is illegal.
REQ-026 cfg_vtype SHALL be zext(insn[30:20]) for vsetvli, zext(insn[29:20]) for vsetivli, and rs2_data for vsetvl.
REQ-027 cfg_avl_new SHALL be zext(insn[19:15]) for vsetivli and rs1_data[31:0] otherwise.
REQ-028 cfg_avl_set SHALL be 10 for vsetivli; otherwise 00 if rs1!=x0, 01 if rs1=x0 and rd!=x0, and 11 if rs1=x0 and rd=x0.
REQ-029 The FSM SHALL use states IDLE, CFG, SETTLE and WB; insn_ready SHALL be high only in IDLE.
REQ-030 IDLE: a handshake on a vset insn SHALL register all cfg_* fields, rd, and the AVL source, then go to CFG.
REQ-031 IDLE: a handshake on an illegal insn SHALL pulse illegal in the next cycle, stay in IDLE, and leave cfg_en low.
REQ-032 CFG SHALL assert cfg_en for exactly one cycle, then go to SETTLE.
REQ-033 SETTLE SHALL sample cfg_avl, cfg_vill and cfg_new_vl.
REQ-034 From SETTLE, the FSM SHALL go to WB when cfg_new_vl=1 and rd!=x0; otherwise it SHALL return to IDLE.
REQ-035 WB SHALL hold wb_valid, wb_rd and wb_data stable until wb_ready; on the handshake cycle it SHALL return to IDLE.
REQ-036 wb_data SHALL be 0 when cfg_vill=1; otherwise it SHALL be cfg_avl zero-extended to XLEN.
REQ-037 Minimum latency SHALL be: accept at cycle 0, cfg_en at cycle 1, wb_valid at cycle 3, next accept at cycle 4 if wb_ready is already high.
REQ-038 The cfg_* outputs SHALL hold their values outside CFG; only cfg_en qualifies them.

Reset
REQ-039 While rst_n=0, the state SHALL be IDLE and every output SHALL be 0 (insn_ready rises after release).
REQ-040 Reset asserted mid-operation SHALL abort any pending writeback without emitting it.

Structure
REQ-041 A shared package SHALL hold the opcode and funct3 constants, the cfg_type and avl_set encodings, and the state enum.
REQ-042 One combinational sub-module, vset_decode (insn, rs1_data, rs2_data to cfg fields and a legal flag), is natural; the FSM SHALL stay in the top module.

Verification
REQ-043 vsetvli rd=x5, rs1=x6 with rs1_data=100, vtype e8 -> cfg_avl_set=00, cfg_avl_new=100, cfg_en at cycle 1; with cfg_avl=100 returned, wb_rd=5 and wb_data=100.
REQ-044 vsetivli uimm=17, rd=x1 -> cfg_type=01, cfg_avl_set=10, cfg_avl_new=17, wb_data equals the returned cfg_avl.
REQ-045 vsetvli rs1=x0, rd=x0, with cfg_new_vl=0 returned -> avl_set=11, no wb_valid, insn_ready back at cycle 3.
REQ-046 vsetvl with cfg_vill=1 and wb_ready held low 5 cycles -> wb_valid held with wb_data=0, insn_ready low until the handshake.
REQ-047 insn=32'h00000013 (addi) -> illegal pulses once, cfg_en stays 0.
REQ-048 rst_n dropped during WB -> wb_valid=0 immediately; after release, a new insn is accepted normally.
